// File: rtl/alu_exception_unit.sv
// Exception/status unit after EX: sticky and last-seen ALU flags, precise exception
// capture (EPC + ExcCode) with a req/ack/flush/handler sequence, and a CP0-style read port.
module alu_exception_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [3:0]  i_alu_control,
  input  logic [7:0]  i_alu_status,
  input  logic [31:0] i_pc_ex,
  input  logic        i_mem_access,
  input  logic        i_is_store,
  input  logic        i_ovf_trap_en,
  input  logic        i_exc_ack,
  input  logic        i_eret,
  input  logic        i_flags_clr,
  input  logic [1:0]  i_cp0_sel,
  output logic        o_exc_req,
  output logic        o_flush,
  output logic        o_in_handler,
  output logic [31:0] o_epc,
  output logic [4:0]  o_exc_cause,
  output logic [31:0] o_cp0_rd_data
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_DIV = 4'b0101;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_DIVZ = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FLUSH,
    ST_HANDLER
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_epc;
  logic [4:0]  r_exc_cause;
  logic [15:0] r_exc_count;
  logic [7:0]  r_dropped_count;
  logic [7:0]  r_sticky;
  logic [7:0]  r_last_status;

  logic        w_adel_ades;
  logic        w_divz;
  logic        w_ov;
  logic        w_exc_det;
  logic [4:0]  w_exc_code;
  logic [7:0]  w_new_flags;
  logic        w_unused_status;

  // Bits [1:0] of the status vector carry no meaning for this unit.
  assign w_unused_status = ^i_alu_status[1:0];
  assign w_new_flags     = {i_alu_status[7:2], 2'b00};

  assign w_adel_ades = i_alu_status[3] & i_mem_access & (i_alu_control == ALU_ADD);
  assign w_divz      = i_alu_status[2] & (i_alu_control == ALU_DIV);
  assign w_ov        = i_alu_status[6] & i_ovf_trap_en &
                       ((i_alu_control == ALU_ADD) | (i_alu_control == ALU_SUB));
  assign w_exc_det   = i_alu_valid & (w_adel_ades | w_divz | w_ov);

  // Address errors outrank divide-by-zero, which outranks overflow.
  always_comb begin
    w_exc_code = EXC_OV;
    if (w_adel_ades) begin
      w_exc_code = i_is_store ? EXC_ADES : EXC_ADEL;
    end else if (w_divz) begin
      w_exc_code = EXC_DIVZ;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_exc_det) w_state_next = ST_REQ;
      ST_REQ:     if (i_exc_ack) w_state_next = ST_FLUSH;
      ST_FLUSH:   w_state_next = ST_HANDLER;
      ST_HANDLER: if (i_eret) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_epc           <= '0;
      r_exc_cause     <= '0;
      r_exc_count     <= '0;
      r_dropped_count <= '0;
      r_sticky        <= '0;
      r_last_status   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_exc_det) begin
        if (r_state == ST_IDLE) begin
          r_epc       <= i_pc_ex;
          r_exc_cause <= w_exc_code;
          if (r_exc_count != 16'hFFFF) r_exc_count <= r_exc_count + 16'd1;
        end else if (r_dropped_count != 8'hFF) begin
          r_dropped_count <= r_dropped_count + 8'd1;
        end
      end
      // A clear in the same cycle as new flags wipes only the old contents.
      if (i_alu_valid) begin
        r_last_status <= w_new_flags;
        r_sticky      <= (i_flags_clr ? 8'h00 : r_sticky) | w_new_flags;
      end else if (i_flags_clr) begin
        r_sticky <= 8'h00;
      end
    end
  end

  assign o_exc_req    = (r_state == ST_REQ);
  assign o_flush      = (r_state == ST_FLUSH);
  assign o_in_handler = (r_state == ST_HANDLER);
  assign o_epc        = r_epc;
  assign o_exc_cause  = r_exc_cause;

  always_comb begin
    o_cp0_rd_data = '0;
    case (i_cp0_sel)
      2'd0: o_cp0_rd_data = {o_in_handler, 24'b0, r_exc_cause, 2'b00};
      2'd1: o_cp0_rd_data = r_epc;
      2'd2: o_cp0_rd_data = {16'b0, r_exc_count};
      2'd3: o_cp0_rd_data = {r_dropped_count, 8'b0, r_last_status, r_sticky};
      default: o_cp0_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_exception_unit.sv
// Bench for alu_exception_unit: directed vector table, hand-written handshake sequences,
// and randomized traffic checked against a behavioural model of the exception rules.
module tb_alu_exception_unit;

  logic        clk = 1'b0;
  logic        rst, alu_valid, mem_access, is_store, ovf_trap_en;
  logic        exc_ack, eret, flags_clr;
  logic [3:0]  alu_control;
  logic [7:0]  alu_status;
  logic [31:0] pc_ex;
  logic [1:0]  cp0_sel;
  logic        exc_req, flush, in_handler;
  logic [31:0] epc, cp0_rd_data;
  logic [4:0]  exc_cause;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic        m_req, m_flush, m_hand;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;
  int          m_cnt, m_drop;
  logic [7:0]  m_sticky, m_last;

  alu_exception_unit dut (
    .i_clk(clk), .i_rst(rst), .i_alu_valid(alu_valid), .i_alu_control(alu_control),
    .i_alu_status(alu_status), .i_pc_ex(pc_ex), .i_mem_access(mem_access),
    .i_is_store(is_store), .i_ovf_trap_en(ovf_trap_en), .i_exc_ack(exc_ack),
    .i_eret(eret), .i_flags_clr(flags_clr), .i_cp0_sel(cp0_sel),
    .o_exc_req(exc_req), .o_flush(flush), .o_in_handler(in_handler), .o_epc(epc),
    .o_exc_cause(exc_cause), .o_cp0_rd_data(cp0_rd_data)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exc_code(input logic [3:0] c, input logic [7:0] s,
                                          input logic mem, input logic st, input logic ov);
    if (s[3] && mem && c == 4'd2) return st ? 5'd5 : 5'd4;
    if (s[2] && c == 4'd5) return 5'd15;
    if (s[6] && ov && (c == 4'd2 || c == 4'd6)) return 5'd12;
    return 5'd0;
  endfunction

  task automatic model_update();
    logic [4:0] c;
    logic busy, n_req, n_flush, n_hand;
    logic [7:0] nf;
    if (rst) begin
      {m_req, m_flush, m_hand} = 3'b000;
      m_epc = 0; m_cause = 0; m_cnt = 0; m_drop = 0; m_sticky = 0; m_last = 0;
      return;
    end
    c = alu_valid ? exc_code(alu_control, alu_status, mem_access, is_store, ovf_trap_en) : 5'd0;
    busy    = m_req | m_flush | m_hand;
    n_req   = m_req & ~exc_ack;
    n_flush = m_req & exc_ack;
    n_hand  = m_flush | (m_hand & ~eret);
    if (c != 0) begin
      if (!busy) begin
        m_epc = pc_ex; m_cause = c; n_req = 1'b1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end else begin
        m_drop = (m_drop < 255) ? m_drop + 1 : m_drop;
      end
    end
    {m_req, m_flush, m_hand} = {n_req, n_flush, n_hand};
    nf = alu_valid ? {alu_status[7:2], 2'b00} : 8'h00;
    if (alu_valid) m_last = nf;
    m_sticky = (flags_clr ? 8'h00 : m_sticky) | nf;
  endtask

  task automatic rd(input logic [1:0] s, output logic [31:0] d);
    cp0_sel = s;
    #1 d = cp0_rd_data;
  endtask

  task automatic check_all();
    logic [31:0] d;
    chk("exc_req", {31'b0, exc_req}, {31'b0, m_req});
    chk("flush", {31'b0, flush}, {31'b0, m_flush});
    chk("in_handler", {31'b0, in_handler}, {31'b0, m_hand});
    chk("epc", epc, m_epc);
    chk("exc_cause", {27'b0, exc_cause}, {27'b0, m_cause});
    rd(2'd0, d); chk("cp0_sel0", d, ({31'b0, m_hand} << 31) | ({27'b0, m_cause} << 2));
    rd(2'd1, d); chk("cp0_sel1", d, m_epc);
    rd(2'd2, d); chk("cp0_sel2", d, m_cnt);
    rd(2'd3, d); chk("cp0_sel3", d, (m_drop << 24) | ({24'b0, m_last} << 8) | {24'b0, m_sticky});
  endtask

  // One clock: inputs already driven, advance model with them, then compare.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1 check_all();
  endtask

  task automatic quiet();
    rst = 0; alu_valid = 0; alu_control = 0; alu_status = 0; pc_ex = 0;
    mem_access = 0; is_store = 0; ovf_trap_en = 0; exc_ack = 0; eret = 0; flags_clr = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1; tick(); rst = 0;
  endtask

  task automatic fault(input logic [3:0] c, input logic [7:0] s, input logic [31:0] pc, input logic ov);
    alu_valid = 1; alu_control = c; alu_status = s; pc_ex = pc; ovf_trap_en = ov;
  endtask

  typedef struct {
    logic       valid;
    logic [3:0] ctrl;
    logic [7:0] status;
    logic       mem, store, ovf;
    logic       exp_req;
    logic [4:0] exp_cause;
    logic [7:0] exp_sticky;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] d;
    logic [3:0]  ctrls[6];
    ctrls = '{4'd2, 4'd6, 4'd5, 4'd0, 4'd7, 4'd1};
    vecs[0]  = '{1, 4'd2, 8'h48, 1, 1, 1, 1, 5'd5,  8'h48};
    vecs[1]  = '{1, 4'd2, 8'h48, 1, 0, 1, 1, 5'd4,  8'h48};
    vecs[2]  = '{1, 4'd2, 8'h40, 0, 0, 0, 0, 5'd0,  8'h40};
    vecs[3]  = '{1, 4'd5, 8'h04, 0, 0, 0, 1, 5'd15, 8'h04};
    vecs[4]  = '{1, 4'd2, 8'h04, 0, 0, 1, 0, 5'd0,  8'h04};
    vecs[5]  = '{1, 4'd6, 8'h40, 0, 0, 1, 1, 5'd12, 8'h40};
    vecs[6]  = '{1, 4'd2, 8'h08, 0, 0, 1, 0, 5'd0,  8'h08};
    vecs[7]  = '{0, 4'd5, 8'h04, 0, 0, 1, 0, 5'd0,  8'h00};
    vecs[8]  = '{1, 4'd7, 8'h44, 1, 0, 1, 0, 5'd0,  8'h44};
    vecs[9]  = '{1, 4'd2, 8'h4B, 1, 0, 0, 1, 5'd4,  8'h48};
    vecs[10] = '{1, 4'd2, 8'h4C, 1, 0, 1, 1, 5'd4,  8'h4C};
    vecs[11] = '{1, 4'd6, 8'h40, 0, 0, 0, 0, 5'd0,  8'h40};

    quiet(); cp0_sel = 0;
    do_reset();
    chk("rst_req", {31'b0, exc_req}, 32'd0);
    rd(2'd3, d); chk("rst_sel3", d, 32'd0);

    // Directed single-instruction table, each from a fresh reset.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      alu_valid = vecs[i].valid; alu_control = vecs[i].ctrl; alu_status = vecs[i].status;
      mem_access = vecs[i].mem; is_store = vecs[i].store; ovf_trap_en = vecs[i].ovf;
      pc_ex = 32'h0040_0000 + 32'(i * 4);
      tick();
      quiet();
      chk("vec_req", {31'b0, exc_req}, {31'b0, vecs[i].exp_req});
      chk("vec_cause", {27'b0, exc_cause}, {27'b0, vecs[i].exp_cause});
      rd(2'd3, d); chk("vec_sticky", {24'b0, d[7:0]}, {24'b0, vecs[i].exp_sticky});
      $display("vec %0d ctrl=%h status=%h req=%0d cause=%0d sticky=%h",
               i, vecs[i].ctrl, vecs[i].status, exc_req, exc_cause, d[7:0]);
    end

    // Overflow trap through the full handshake.
    do_reset();
    fault(4'd2, 8'h40, 32'h0040_0010, 1); tick(); quiet();
    chk("ov_req", {31'b0, exc_req}, 32'd1);
    chk("ov_cause", {27'b0, exc_cause}, 32'd12);
    chk("ov_epc", epc, 32'h0040_0010);
    tick(); tick();
    chk("ov_req_hold", {31'b0, exc_req}, 32'd1);
    exc_ack = 1; tick(); exc_ack = 0;
    chk("ov_flush", {31'b0, flush}, 32'd1);
    chk("ov_req_drop", {31'b0, exc_req}, 32'd0);
    tick();
    chk("ov_flush_end", {31'b0, flush}, 32'd0);
    chk("ov_handler", {31'b0, in_handler}, 32'd1);
    eret = 1; tick(); eret = 0;
    chk("ov_eret", {31'b0, in_handler}, 32'd0);
    $display("seq overflow trap done");

    // Nested drops in handler, eret colliding with a fault, then re-acceptance.
    do_reset();
    fault(4'd2, 8'h40, 32'h0000_1000, 1); tick(); quiet();
    exc_ack = 1; tick(); exc_ack = 0; tick();
    for (int k = 0; k < 3; k++) begin
      fault(4'd5, 8'h04, 32'h0000_2000 + 32'(k), 0); tick();
    end
    quiet();
    chk("nest_epc", epc, 32'h0000_1000);
    chk("nest_cause", {27'b0, exc_cause}, 32'd12);
    rd(2'd3, d); chk("nest_drop3", {24'b0, d[31:24]}, 32'd3);
    fault(4'd5, 8'h04, 32'h0000_3000, 0); eret = 1; tick(); quiet();
    chk("nest_eret", {31'b0, in_handler}, 32'd0);
    chk("nest_eret_req", {31'b0, exc_req}, 32'd0);
    rd(2'd3, d); chk("nest_drop4", {24'b0, d[31:24]}, 32'd4);
    fault(4'd5, 8'h04, 32'h0000_4000, 0); tick(); quiet();
    chk("nest_accept", {31'b0, exc_req}, 32'd1);
    chk("nest_accept_cause", {27'b0, exc_cause}, 32'd15);
    rd(2'd2, d); chk("nest_count", d, 32'd2);
    $display("seq nested drop done");

    // Dropped counter saturation at 255.
    exc_ack = 1; tick(); exc_ack = 0; tick();
    for (int k = 0; k < 260; k++) begin
      fault(4'd5, 8'h04, 32'h0000_5000, 0); tick();
    end
    quiet();
    rd(2'd3, d); chk("drop_sat", {24'b0, d[31:24]}, 32'd255);
    $display("seq dropped saturation done");

    // Sticky accumulation and clear-with-new-flags.
    do_reset();
    fault(4'd0, 8'h80, 0, 0); tick();
    fault(4'd0, 8'h10, 0, 0); tick(); quiet();
    rd(2'd3, d);
    chk("sticky_or", {24'b0, d[7:0]}, 32'h90);
    chk("last_status", {24'b0, d[15:8]}, 32'h10);
    fault(4'd0, 8'h40, 0, 0); flags_clr = 1; tick(); quiet();
    rd(2'd3, d); chk("sticky_clr_new", {24'b0, d[7:0]}, 32'h40);
    flags_clr = 1; tick(); quiet();
    rd(2'd3, d); chk("sticky_clr", {24'b0, d[7:0]}, 32'h00);
    $display("seq sticky done");

    // Reset while a request is pending; a late ack must be ignored.
    do_reset();
    fault(4'd2, 8'h40, 32'h0040_0010, 1); tick(); quiet();
    chk("rreq_pending", {31'b0, exc_req}, 32'd1);
    rst = 1; exc_ack = 1; tick(); quiet();
    chk("rreq_req", {31'b0, exc_req}, 32'd0);
    chk("rreq_epc", epc, 32'd0);
    rd(2'd2, d); chk("rreq_count", d, 32'd0);
    rd(2'd0, d); chk("rreq_sel0", d, 32'd0);
    exc_ack = 1; tick(); quiet();
    chk("rreq_late_ack", {31'b0, flush}, 32'd0);
    $display("seq reset in REQ done");

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      alu_valid   = ($urandom_range(0, 9) < 6);
      alu_control = ctrls[$urandom_range(0, 5)];
      alu_status  = 8'($urandom());
      pc_ex       = $urandom();
      mem_access  = 1'($urandom());
      is_store    = 1'($urandom());
      ovf_trap_en = 1'($urandom());
      exc_ack     = ($urandom_range(0, 9) < 3);
      eret        = ($urandom_range(0, 3) == 0);
      flags_clr   = ($urandom_range(0, 19) == 0);
      tick();
    end
    quiet();
    $display("random phase done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exception_unit.md
# alu_exception_unit

Sequential exception and status unit for the MIPS datapath. It sits after the EX stage and consumes the ALU's 8-bit status vector together with the ALU control code. It keeps sticky and last-seen flag registers and raises precise arithmetic/address exceptions to the main control FSM through a request/acknowledge handshake. It also captures EPC and cause, and exposes them through a CP0-style read port.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  alu_status/alu_control/pc_ex describe a committing EX-stage instruction this cycle
- alu_control  in  4  ALU operation code (0010 add, 0110 sub, 0101 div, others)
- alu_status  in  8  ALU flags:
  - [7] zero
  - [6] 32-bit overflow
  - [5] magnitude growth
  - [4] negative
  - [3] add result not word-aligned
  - [2] divide by zero
  - [1:0] unused, ignored
- mem_access  in  1  current add is a load/store address computation
- is_store  in  1  qualifies mem_access (1 = store)
- ovf_trap_en  in  1  signed add/sub traps on overflow (0 for addu/subu)
- exc_ack  in  1  control FSM accepts pending exception
- eret  in  1  return from handler
- flags_clr  in  1  clear sticky flags
- cp0_sel  in  2  read select
- exc_req  out  1  exception pending
- flush  out  1  one-cycle pipeline flush pulse
- in_handler  out  1  handler in progress
- epc  out  32  PC of faulting instruction
- exc_cause  out  5  MIPS ExcCode
- cp0_rd_data  out  32  read data

## Operation
- Exception detect, evaluated only when alu_valid=1, in priority order:
  - AdEL/AdES (4/5): alu_status[3] & mem_access & alu_control==0010; is_store selects 5.
  - DivZ (15): alu_status[2] & alu_control==0101.
  - Ov (12): alu_status[6] & ovf_trap_en & alu_control ∈ {0010,0110}.
- FSM states:
  - IDLE: a detected exception loads epc←pc_ex and exc_cause, increments exc_count, and moves to REQ.
  - REQ: exc_req=1. exc_ack=1 moves to FLUSH.
  - FLUSH: flush=1 for exactly one cycle, then moves to HANDLER.
  - HANDLER: in_handler=1. eret=1 moves to IDLE.
- A detection in any state other than IDLE does not change epc or exc_cause and increments dropped_count.
- exc_ack outside REQ is ignored. eret outside HANDLER is ignored.
- Sticky flags: when alu_valid=1, sticky[7:0] ← sticky | {alu_status[7:2],2'b00}. This happens in every state.
- Last status: when alu_valid=1, last_status ← {alu_status[7:2],2'b00}.
- flags_clr together with alu_valid in the same cycle: sticky ← new flags only (the clear applies to the old contents).
- exc_count is 16 bits and dropped_count is 8 bits. Both saturate at all-ones and never wrap.
- cp0_rd_data is a combinational mux of registered values:
  - sel 0: {in_handler, 24'b0, exc_cause, 2'b00}; ExcCode sits at bits [6:2].
  - sel 1: epc.
  - sel 2: {16'b0, exc_count}.
  - sel 3: {dropped_count, 8'b0, last_status, sticky}.

## Timing
- Reset: all outputs, epc, exc_cause, sticky, last_status and both counters are 0; state is IDLE. Reset overrides every other input in the same cycle, including in mid-handshake.
- Exception sampled at edge N: exc_req=1 from cycle N+1; epc/exc_cause are valid from N+1.
- exc_ack sampled high at edge M while in REQ: exc_req=0 and flush=1 in cycle M+1; in_handler=1 from M+2.
- exc_req stays high indefinitely until exc_ack.
- eret sampled in HANDLER at edge K: in_handler=0 and state IDLE from K+1. An exception detected at edge K+1 is accepted.
- eret and a detected exception at the same edge in HANDLER: eret wins, and the exception is dropped and counted.
- Detection with alu_valid=0 never has effect.
- Zero-latency read: cp0_rd_data follows cp0_sel within the cycle and reflects register state after the last edge.

## Test plan
- Overflow trap: add, alu_status=0x40, ovf_trap_en=1, pc_ex=0x00400010 → exc_req=1 next cycle, exc_cause=12, epc=0x00400010. Ack → flush is a one-cycle pulse, then in_handler=1. eret → IDLE.
- Priority: alu_control=0010, alu_status=0x48, mem_access=1, is_store=1, ovf_trap_en=1 → exc_cause=5, not 12. Same case with is_store=0 → 4.
- Masked and non-trapping cases:
  - addu overflow (ovf_trap_en=0) → no exc_req; sticky[6]=1.
  - div with alu_status=0x04 → exc_cause=15.
  - alu_status=0x04 with alu_control=0010 → no exception.
- Nested drop: while in HANDLER, apply three faulting instructions → epc/cause unchanged, dropped_count=3. eret in the same cycle as a fault → IDLE, and dropped_count increments.
- Stickiness and clear: statuses 0x80 then 0x10 → sel3 low byte 0x90, last_status 0x10. flags_clr with status 0x40 in the same cycle → sticky=0x40.
- Reset in REQ with exc_req=1 → next cycle exc_req=0, epc=0, exc_count=0, cp0_rd_data(sel0)=0. Late exc_ack is ignored.
